// File: rtl/dmem_sched_pkg.sv
// Shared definitions for the data-RAM scheduler: FSM states and entry sizing.
// Pure declarations; no logic and no latency of its own.
// Imported by the scheduler top and its receiver write buffer.
package dmem_sched_pkg;

  localparam int DATA_W  = 24;
  localparam int DMEM_AW = 14;

  // Who owns the RAM port this cycle, plus the handshake states around it.
  typedef enum logic [2:0] {
    IDLE,
    RX,
    NOTIFY,
    CPU_RUN,
    RD,
    RD_DATA
  } state_t;

  // A buffered receiver write is {last, addr, data}: 1 + aw + 24 bits.
  function automatic int rx_entry_w(input int aw);
    return aw + DATA_W + 1;
  endfunction

endpackage

// File: rtl/dmem_scheduler_rx_wr_fifo.sv
// Receiver write buffer: synchronous first-word-fall-through FIFO.
// Latency: an entry pushed at an edge is visible on pop_data the next cycle.
// Backpressure: full blocks push unless a pop happens in the same cycle.
module rx_wr_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_scheduler.sv
// Arbitrates the single-port data RAM between receiver, cpu24 core and readout.
// Latency: rx word reaches RAM >=2 cycles after accept; readout data 1 cycle after rd_gnt.
// Backpressure: rx_ready drops when the write buffer is full; rd_req waits for IDLE.
module dmem_scheduler import dmem_sched_pkg::*; #(
  parameter int DATA_AW       = DMEM_AW,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [DATA_AW-1:0] rx_addr,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_last,
  input  logic               cpu_halt,
  input  logic               cpu_we,
  input  logic [DATA_AW-1:0] cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               pkt_done,
  input  logic               rd_req,
  input  logic [DATA_AW-1:0] rd_addr,
  output logic               rd_gnt,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               ram_we,
  output logic [DATA_AW-1:0] ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [15:0]        pkt_count,
  output logic               err_start
);

  localparam int EW = rx_entry_w(DATA_AW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [TW-1:0]      wait_cnt;

  logic [EW-1:0]      push_entry;
  logic [EW-1:0]      head;
  logic               head_last;
  logic [DATA_AW-1:0] head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               push;
  logic               pop;

  assign push_entry = {rx_last, rx_addr, rx_data};
  assign {head_last, head_addr, head_data} = head;

  // rx_ready depends only on registered state, never on rx_valid.
  assign pop       = (state == RX) && !fifo_empty;
  assign rx_ready  = !fifo_full || pop;
  assign push      = rx_valid && rx_ready;
  assign cpu_rdata = ram_rdata;

  rx_wr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register, core-start wait timer, packet counter and sticky start error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pkt_count <= '0;
      err_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == NOTIFY) ? wait_cnt + 1'b1 : '0;
      if (state == RX && state_nxt == NOTIFY) pkt_count <= pkt_count + 16'd1;
      if (state == NOTIFY && state_nxt == IDLE) err_start <= 1'b1;
    end
  end

  // Next state and the RAM/readout muxes for whoever owns the port this cycle.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    pkt_done  = 1'b0;
    rd_gnt    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    case (state)
      IDLE: begin
        // Buffered receiver words always beat a pending readout.
        if (!fifo_empty)  state_nxt = RX;
        else if (rd_req)  state_nxt = RD;
      end
      RX: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
        end else begin
          ram_we    = 1'b1;
          ram_addr  = head_addr;
          ram_wdata = head_data;
          // Stop at a packet boundary; later words wait for the next halt.
          if (head_last)                              state_nxt = NOTIFY;
          else if (fifo_count == CW'(1) && !push)     state_nxt = IDLE;
        end
      end
      NOTIFY: begin
        pkt_done = 1'b1;
        // Never release on the first cycle so the core sees receive_done for >=2 cycles.
        if (!cpu_halt && wait_cnt != '0)                       state_nxt = CPU_RUN;
        else if (cpu_halt && wait_cnt == TW'(START_TIMEOUT - 1)) state_nxt = IDLE;
      end
      CPU_RUN: begin
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (cpu_halt) state_nxt = IDLE;
      end
      RD: begin
        ram_addr  = rd_addr;
        rd_gnt    = 1'b1;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rd_valid  = 1'b1;
        rd_data   = ram_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_scheduler.sv
// Bench for dmem_scheduler: directed scenarios plus a queue/array reference model.
// The model tracks accepted receiver words, expected RAM contents and packet count.
// A negedge compare process checks RAM writes, rx_ready, pkt_count and readouts.
module tb_dmem_scheduler;

  localparam int AW    = 14;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } rxw_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] rx_addr;
  logic [23:0]   rx_data;
  logic          rx_last;
  logic          cpu_halt;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [23:0]   cpu_wdata;
  logic [23:0]   cpu_rdata;
  logic          pkt_done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [23:0]   rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_wdata;
  logic [23:0]   ram_rdata;
  logic [15:0]   pkt_count;
  logic          err_start;

  int total  = 0;
  int bad    = 0;
  int wr_cnt = 0;
  int m_pkts = 0;

  rxw_t        mq[$];
  logic [23:0] m_mem   [0:(1<<AW)-1];
  logic [23:0] ram_mem [0:(1<<AW)-1];
  logic        gnt_pend = 1'b0;
  logic [23:0] gnt_exp;

  always #5 clk = ~clk;

  dmem_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .rx_last   (rx_last),
    .cpu_halt  (cpu_halt),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .pkt_done  (pkt_done),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .pkt_count (pkt_count),
    .err_start (err_start)
  );

  // Single-port synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [23:0] d, input logic l);
    int n = 0;
    rx_valid = 1'b1;
    rx_addr  = a;
    rx_data  = d;
    rx_last  = l;
    while (!rx_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_wait_bound", 32'(n < 100), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  // Reference model: receiver words land in acceptance order only while the core is halted;
  // while the core runs the RAM port follows the core; a readout returns the model RAM word.
  always @(negedge clk) begin
    rxw_t h;
    int   occ;
    logic rx_pop;
    if (rst) begin
      mq.delete();
      m_pkts   = 0;
      gnt_pend = 1'b0;
    end else begin
      occ    = mq.size();
      rx_pop = cpu_halt && ram_we;
      chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
      if (!cpu_halt) begin
        chk("cpu_owns_we", 32'(ram_we), 32'(cpu_we));
        if (ram_we) begin
          chk("cpu_wr_addr", 32'(ram_addr), 32'(cpu_addr));
          chk("cpu_wr_data", 32'(ram_wdata), 32'(cpu_wdata));
          m_mem[cpu_addr] = cpu_wdata;
        end
      end else if (ram_we) begin
        if (occ == 0) begin
          total++;
          bad++;
          $display("FAIL rx_wr_unexpected: write addr 0x%0h with no buffered word at %0t",
                   ram_addr, $time);
        end else begin
          h = mq.pop_front();
          chk("rx_wr_addr", 32'(ram_addr), 32'(h.addr));
          chk("rx_wr_data", 32'(ram_wdata), 32'(h.data));
          m_mem[h.addr] = h.data;
          wr_cnt++;
          if (h.last) m_pkts++;
        end
      end
      if (occ < DEPTH) chk("rx_ready_room", 32'(rx_ready), 32'd1);
      else             chk("rx_ready_full", 32'(rx_ready), 32'(rx_pop));
      if (gnt_pend) begin
        chk("rd_valid_after_gnt", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(gnt_exp));
        gnt_pend = 1'b0;
      end else begin
        chk("rd_valid_quiet", 32'(rd_valid), 32'd0);
      end
      if (rd_gnt) begin
        chk("rd_gnt_addr", 32'(ram_addr), 32'(rd_addr));
        chk("rd_gnt_fifo_drained", 32'(occ), 32'd0);
        gnt_exp  = m_mem[rd_addr];
        gnt_pend = 1'b1;
      end
      if (rx_valid && rx_ready) mq.push_back(rxw_t'({rx_last, rx_addr, rx_data}));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    rst = 1'b1;  rx_valid = 1'b0; rx_addr = '0; rx_data = '0; rx_last = 1'b0;
    cpu_halt = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rd_req = 1'b0; rd_addr = '0;
    tick();
    tick();
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_rx_ready",  32'(rx_ready),  32'd1);
    chk("rst_pkt_done",  32'(pkt_done),  32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err_start", 32'(err_start), 32'd0);
    chk("rst_rd_gnt",    32'(rd_gnt),    32'd0);
    rst = 1'b0;
    tick();

    // 1: three-word packet with the core halted
    for (int i = 0; i < 3; i++) push_word(AW'(i), 24'hA0000 + 24'(i), logic'(i == 2));
    chk("t1_we_word1", 32'(ram_we), 32'd1);
    tick();
    chk("t1_we_word2", 32'(ram_we),   32'd1);
    chk("t1_pd_low",   32'(pkt_done), 32'd0);
    tick();
    chk("t1_pd_high",  32'(pkt_done),  32'd1);
    chk("t1_we_off",   32'(ram_we),    32'd0);
    chk("t1_pkt_cnt",  32'(pkt_count), 32'd1);
    chk("t1_writes",   32'(wr_cnt),    32'd3);

    // 2: core starts two cycles after pkt_done, writes then reads 0x0100
    tick();
    tick();
    cpu_halt = 1'b0;
    #1;
    chk("t2_pd_held", 32'(pkt_done), 32'd1);
    tick();
    chk("t2_pd_drop", 32'(pkt_done), 32'd0);
    cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 24'h123456;
    #1;
    chk("t2_cpu_we",   32'(ram_we),   32'd1);
    chk("t2_cpu_addr", 32'(ram_addr), 32'h100);
    tick();
    cpu_we = 1'b0;
    tick();
    chk("t2_readback", 32'(cpu_rdata), 32'h123456);

    // 3: five words pushed while the core runs; depth is four
    for (int i = 0; i < 4; i++) push_word(AW'(14'h10 + i), 24'hB0000 + 24'(i), 1'b0);
    chk("t3_full", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1; rx_addr = 14'h14; rx_data = 24'hB0004; rx_last = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_still_full", 32'(rx_ready), 32'd0);
    chk("t3_no_rx_wr",   32'(wr_cnt),   32'd3);
    cpu_halt = 1'b1;
    push_word(14'h14, 24'hB0004, 1'b0);
    n = 0;
    while (mq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("t3_drain_bound", 32'(n < 50), 32'd1);
    chk("t3_all_landed",  32'(wr_cnt), 32'd8);
    tick();
    tick();

    // 4: readout request while receiver words are still buffered
    push_word(14'h30, 24'hC0030, 1'b0);
    rx_valid = 1'b1; rx_addr = 14'h31; rx_data = 24'hC0031; rx_last = 1'b0;
    rd_req = 1'b1; rd_addr = 14'h0002;
    tick();
    rx_valid = 1'b0;
    n = 0;
    while (!rd_gnt && n < 20) begin
      tick();
      n++;
    end
    chk("t4_gnt_bound",    32'(n < 20),   32'd1);
    chk("t4_rx_before_rd", 32'(wr_cnt),   32'd10);
    chk("t4_gnt_addr",     32'(ram_addr), 32'h2);
    tick();
    rd_req = 1'b0;
    chk("t4_rd_valid", 32'(rd_valid), 32'd1);
    chk("t4_rd_data",  32'(rd_data),  32'hA0002);
    tick();

    // 5: core never starts; start timeout
    push_word(14'h40, 24'hD0040, 1'b1);
    n = 0;
    while (!pkt_done && n < 20) begin
      tick();
      n++;
    end
    chk("t5_pd_bound",   32'(n < 20),    32'd1);
    chk("t5_err_before", 32'(err_start), 32'd0);
    chk("t5_pkt_count",  32'(pkt_count), 32'd2);
    n = 0;
    while (pkt_done && n < 40) begin
      tick();
      n++;
    end
    chk("t5_pd_cycles", 32'(n),         32'd16);
    chk("t5_err_after", 32'(err_start), 32'd1);
    rd_req = 1'b1; rd_addr = 14'h40;
    n = 0;
    while (!rd_gnt && n < 10) begin
      tick();
      n++;
    end
    chk("t5_idle_gnt", 32'(n < 10), 32'd1);
    tick();
    rd_req = 1'b0;
    chk("t5_rd_data", 32'(rd_data), 32'hD0040);
    tick();

    // 6: reset in the middle of draining a packet
    base = wr_cnt;
    for (int i = 0; i < 3; i++) push_word(AW'(14'h50 + i), 24'hE0050 + 24'(i), logic'(i == 2));
    rst = 1'b1;
    #1;
    chk("t6_we_off",     32'(ram_we),    32'd0);
    chk("t6_rx_ready",   32'(rx_ready),  32'd1);
    chk("t6_pkt_count",  32'(pkt_count), 32'd0);
    chk("t6_one_landed", 32'(wr_cnt),    32'(base + 1));
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_more_wr", 32'(wr_cnt),    32'(base + 1));
    chk("t6_err_clear",  32'(err_start), 32'd0);
    chk("t6_pd_low",     32'(pkt_done),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
